// File: rtl/bus_bridge_uart_framer.sv
// bus_bridge_uart_framer: sends bus requests as checksummed UART frames and collects the matching
// response frame; a missing or corrupt reply is retried a bounded number of times, then reported as an error
module bus_bridge_uart_framer #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 8,
  parameter int TIMEOUT_CYCLES = 100000,
  parameter int MAX_RETRY = 2,
  parameter logic [7:0] SYNC_BYTE = 8'hA5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  input  logic              req_is_write,
  output logic              req_ready,
  output logic              resp_valid,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_is_write,
  output logic              resp_err,
  input  logic              resp_ready,
  output logic [7:0]        tx_data,
  output logic              tx_wr_en,
  input  logic              tx_busy,
  input  logic [7:0]        rx_data,
  input  logic              rx_ready,
  output logic              rx_ready_clr
);
  localparam int AB = ADDR_W / 8;
  localparam int DB = DATA_W / 8;
  localparam int PL = 1 + AB + DB;
  localparam int NB = PL + 2;
  localparam int IW = $clog2(NB);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int RW = $clog2(MAX_RETRY + 2);
  localparam int CW = $clog2(DB + 1);
  localparam logic [IW-1:0] I_LAST = IW'(NB - 1);
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [RW-1:0] R_MAX = RW'(MAX_RETRY);
  localparam logic [CW-1:0] C_LAST = CW'(DB - 1);

  typedef enum logic [1:0] {IDLE, SEND, WAIT, AWAIT_RESP} tx_state_t;
  typedef enum logic [2:0] {HUNT, FLAGS, DATA, CHECK, HOLD} rx_state_t;

  tx_state_t         tx_state;
  rx_state_t         rx_state;
  logic [NB*8-1:0]   frame, new_frame;
  logic [PL*8-1:0]   payload;
  logic [7:0]        csum;
  logic [IW-1:0]     idx;
  logic [TW-1:0]     tcnt;
  logic [RW-1:0]     retries;
  logic [1:0]        seq;
  logic              busy_q;
  logic              rx_ready_q, rx_rise;
  logic [3:0]        rx_flags;
  logic [7:0]        rx_csum;
  logic [DATA_W-1:0] rx_buf;
  logic [CW-1:0]     rx_cnt;
  logic              good_frame, timeout_hit, retry_start, give_up;

  // The whole frame is built once at acceptance so a retry replays it byte-for-byte
  always_comb begin
    payload = {{DATA_W{req_is_write}} & req_wdata, req_addr, 5'b0, seq, req_is_write};
    csum = '0;
    for (int i = 0; i < PL; i++) csum ^= payload[i*8 +: 8];
    new_frame = {csum, payload, SYNC_BYTE};
  end

  assign rx_rise     = rx_ready && !rx_ready_q;
  assign good_frame  = rx_state == CHECK && rx_rise && rx_data == rx_csum &&
                       rx_flags[2:0] == frame[10:8] && tx_state == AWAIT_RESP;
  assign timeout_hit = tx_state == AWAIT_RESP && tcnt == T_LAST && !good_frame;
  assign retry_start = timeout_hit && retries < R_MAX;
  assign give_up     = timeout_hit && !(retries < R_MAX);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_state  <= IDLE;
      req_ready <= 1'b0;
      tx_data   <= '0;
      tx_wr_en  <= 1'b0;
      busy_q    <= 1'b0;
      frame     <= '0;
      idx       <= '0;
      tcnt      <= '0;
      retries   <= '0;
      seq       <= '0;
    end else begin
      tx_wr_en <= 1'b0;
      busy_q   <= tx_busy;
      case (tx_state)
        IDLE:
          if (req_valid && req_ready) begin
            frame     <= new_frame;
            seq       <= seq + 2'd1;
            retries   <= '0;
            idx       <= '0;
            req_ready <= 1'b0;
            tx_state  <= SEND;
          end else req_ready <= !(resp_valid && !resp_ready);
        SEND:
          if (!tx_busy) begin
            tx_data  <= frame[idx*8 +: 8];
            tx_wr_en <= 1'b1;
            tx_state <= WAIT;
          end
        WAIT:
          if (busy_q && !tx_busy) begin
            idx      <= idx + 1'b1;
            tcnt     <= '0;
            tx_state <= idx == I_LAST ? AWAIT_RESP : SEND;
          end
        AWAIT_RESP: begin
          tcnt <= tcnt + 1'b1;
          if (good_frame || give_up) tx_state <= IDLE;
          else if (retry_start) begin
            retries  <= retries + 1'b1;
            idx      <= '0;
            tx_state <= SEND;
          end
        end
        default: tx_state <= IDLE;
      endcase
    end
  end

  // Response registers are owned here; a timeout give-up reports through the same path
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_state      <= HUNT;
      rx_ready_q    <= 1'b0;
      rx_ready_clr  <= 1'b0;
      rx_flags      <= '0;
      rx_csum       <= '0;
      rx_buf        <= '0;
      rx_cnt        <= '0;
      resp_valid    <= 1'b0;
      resp_rdata    <= '0;
      resp_is_write <= 1'b0;
      resp_err      <= 1'b0;
    end else begin
      rx_ready_q   <= rx_ready;
      rx_ready_clr <= rx_rise;
      if (retry_start) rx_state <= HUNT;
      else if (rx_rise || rx_state == HOLD)
        case (rx_state)
          HUNT: if (rx_data == SYNC_BYTE) rx_state <= FLAGS;
          FLAGS: begin
            rx_flags <= rx_data[3:0];
            rx_csum  <= rx_data;
            rx_cnt   <= '0;
            rx_state <= DATA;
          end
          DATA: begin
            rx_buf   <= (rx_buf >> 8) | (DATA_W'(rx_data) << (DATA_W - 8));
            rx_csum  <= rx_csum ^ rx_data;
            rx_cnt   <= rx_cnt + 1'b1;
            rx_state <= rx_cnt == C_LAST ? CHECK : DATA;
          end
          CHECK: rx_state <= good_frame ? HOLD : HUNT;
          HOLD: if (resp_valid && resp_ready) rx_state <= HUNT;
          default: rx_state <= HUNT;
        endcase
      if (good_frame) begin
        resp_valid    <= 1'b1;
        resp_rdata    <= rx_buf;
        resp_is_write <= rx_flags[0];
        resp_err      <= rx_flags[3];
      end else if (give_up) begin
        resp_valid    <= 1'b1;
        resp_rdata    <= '0;
        resp_is_write <= frame[8];
        resp_err      <= 1'b1;
      end else if (resp_valid && resp_ready) begin
        resp_valid    <= 1'b0;
        resp_rdata    <= '0;
        resp_is_write <= 1'b0;
        resp_err      <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_bus_bridge_uart_framer.sv
// tb_bus_bridge_uart_framer: vector table, corner sequences and random traffic against a byte-queue frame model
module tb_bus_bridge_uart_framer;
  localparam int TO = 40;
  typedef logic [7:0] bq_t[$];
  typedef struct {
    logic        w;
    logic [15:0] a;
    logic [7:0]  d;
    logic [47:0] f;
    logic [7:0]  rd;
    logic        e;
    int          hold;
    logic        garb;
  } vec_t;

  logic clk = 0, rst = 1;
  always #5 clk = ~clk;
  int checks = 0, errors = 0, cyc = 0;
  logic [1:0] mseq = 0;

  logic req_valid0 = 0, req_is_write0 = 0, req_ready0, resp_ready0 = 0;
  logic [15:0] req_addr0 = 0;
  logic [7:0] req_wdata0 = 0, resp_rdata0, tx_data0;
  logic resp_valid0, resp_is_write0, resp_err0, tx_wr_en0, tx_busy0, clr0;
  logic req_valid1 = 0, req_is_write1 = 0, req_ready1, resp_ready1 = 0;
  logic [23:0] req_addr1 = 0;
  logic [31:0] req_wdata1 = 0, resp_rdata1;
  logic [7:0] tx_data1;
  logic resp_valid1, resp_is_write1, resp_err1, tx_wr_en1, tx_busy1, clr1;
  logic [7:0] rx_data = 0;
  logic rx_ready = 0;
  bq_t txq0, txq1;
  int txt0[$];
  int bc0, bc1;

  bus_bridge_uart_framer #(.ADDR_W(16), .DATA_W(8), .TIMEOUT_CYCLES(TO), .MAX_RETRY(2)) dut0 (
    .clk(clk), .rst(rst), .req_valid(req_valid0), .req_addr(req_addr0), .req_wdata(req_wdata0),
    .req_is_write(req_is_write0), .req_ready(req_ready0), .resp_valid(resp_valid0), .resp_rdata(resp_rdata0),
    .resp_is_write(resp_is_write0), .resp_err(resp_err0), .resp_ready(resp_ready0), .tx_data(tx_data0),
    .tx_wr_en(tx_wr_en0), .tx_busy(tx_busy0), .rx_data(rx_data), .rx_ready(rx_ready), .rx_ready_clr(clr0));

  bus_bridge_uart_framer #(.ADDR_W(24), .DATA_W(32), .TIMEOUT_CYCLES(TO), .MAX_RETRY(2)) dut1 (
    .clk(clk), .rst(rst), .req_valid(req_valid1), .req_addr(req_addr1), .req_wdata(req_wdata1),
    .req_is_write(req_is_write1), .req_ready(req_ready1), .resp_valid(resp_valid1), .resp_rdata(resp_rdata1),
    .resp_is_write(resp_is_write1), .resp_err(resp_err1), .resp_ready(resp_ready1), .tx_data(tx_data1),
    .tx_wr_en(tx_wr_en1), .tx_busy(tx_busy1), .rx_data(rx_data), .rx_ready(rx_ready), .rx_ready_clr(clr1));

  // UART transmitter models: capture each written byte, then stay busy for a few cycles
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rst) begin tx_busy0 <= 0; bc0 <= 0; end
    else if (tx_wr_en0) begin txq0.push_back(tx_data0); txt0.push_back(cyc); tx_busy0 <= 1; bc0 <= 3; end
    else if (bc0 != 0) begin bc0 <= bc0 - 1; if (bc0 == 1) tx_busy0 <= 0; end
    if (rst) begin tx_busy1 <= 0; bc1 <= 0; end
    else if (tx_wr_en1) begin txq1.push_back(tx_data1); tx_busy1 <= 1; bc1 <= 3; end
    else if (bc1 != 0) begin bc1 <= bc1 - 1; if (bc1 == 1) tx_busy1 <= 0; end
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
    end
  endtask

  function automatic void build_req(input logic w, input logic [1:0] s, input logic [63:0] a,
                                    input logic [63:0] d, input int ab, input int db, output bq_t q);
    logic [7:0] x = 0;
    q = {};
    q.push_back(8'hA5);
    q.push_back({5'b0, s, w});
    for (int i = 0; i < ab; i++) q.push_back(a[8*i +: 8]);
    for (int i = 0; i < db; i++) q.push_back(w ? d[8*i +: 8] : 8'h00);
    for (int i = 1; i < q.size(); i++) x ^= q[i];
    q.push_back(x);
  endfunction

  function automatic void build_rsp(input logic [7:0] f, input logic [63:0] d, input int db, output bq_t q);
    logic [7:0] x = f;
    q = {};
    q.push_back(8'hA5);
    q.push_back(f);
    for (int i = 0; i < db; i++) begin q.push_back(d[8*i +: 8]); x ^= d[8*i +: 8]; end
    q.push_back(x);
  endfunction

  function automatic void lit2q(input logic [47:0] f, output bq_t q);
    q = {};
    for (int i = 0; i < 6; i++) q.push_back(f[8*(5-i) +: 8]);
  endfunction

  task automatic rx_byte(input logic [7:0] b);
    int n = 0;
    @(negedge clk);
    rx_data = b;
    rx_ready = 1;
    while (!(clr0 || clr1) && n < 20) begin @(negedge clk); n++; end
    if (n == 20) chk("rx_clr_pulse", 0, 1);
    rx_ready = 0;
  endtask

  task automatic send_q(input bq_t r);
    foreach (r[i]) rx_byte(r[i]);
  endtask

  task automatic wait_tx0(input int n);
    int k = 0;
    while (txq0.size() < n && k < 3000) begin @(negedge clk); k++; end
    chk("tx_byte_count", txq0.size(), n);
  endtask

  task automatic cmp_tx0(input string nm, input bq_t ef, input int off);
    foreach (ef[i]) chk(nm, (off + i < txq0.size()) ? txq0[off+i] : 8'hxx, ef[i]);
  endtask

  task automatic req0(input logic w, input logic [15:0] a, input logic [7:0] d);
    int k = 0;
    txq0.delete();
    txt0.delete();
    req_is_write0 = w; req_addr0 = a; req_wdata0 = d; req_valid0 = 1;
    while (!req_ready0 && k < 50) begin @(negedge clk); k++; end
    if (!req_ready0) chk("req_ready_wait", req_ready0, 1);
    @(negedge clk);
    req_valid0 = 0;
    chk("req_ready_after_accept", req_ready0, 0);
    mseq = mseq + 2'd1;
  endtask

  task automatic wait_resp0(input int lim);
    int k = 0;
    while (!resp_valid0 && k < lim) begin @(negedge clk); k++; end
    chk("resp_valid", resp_valid0, 1);
  endtask

  task automatic ack0();
    resp_ready0 = 1;
    @(negedge clk);
    resp_ready0 = 0;
    chk("resp_valid_drop", resp_valid0, 0);
    chk("req_ready_return", req_ready0, 1);
  endtask

  task automatic txn0(input logic w, input logic [15:0] a, input logic [7:0] d, input bq_t ef,
                      input logic [7:0] rd, input logic e, input int hold, input logic garb);
    bq_t r;
    req0(w, a, d);
    wait_tx0(ef.size());
    cmp_tx0("frame_byte", ef, 0);
    if (garb) begin rx_byte(8'h11); rx_byte(8'h22); end
    build_rsp(ef[1] | {4'b0, e, 3'b0}, 64'(rd), 1, r);
    send_q(r);
    wait_resp0(100);
    chk("resp_rdata", resp_rdata0, rd);
    chk("resp_is_write", resp_is_write0, w);
    chk("resp_err", resp_err0, e);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk("hold_valid", resp_valid0, 1);
      chk("hold_rdata", resp_rdata0, rd);
      chk("hold_err", resp_err0, e);
      chk("hold_req_blocked", req_ready0, 0);
    end
    ack0();
  endtask

  initial begin
    vec_t tbl[4];
    bq_t q, r;
    int k, n, gap;
    logic seen;
    logic w, e, garb;
    logic [15:0] a;
    logic [7:0] d, rd;
    tbl[0] = '{1'b1, 16'h4012, 8'h5C, 48'hA5_01_12_40_5C_0F, 8'h00, 1'b0, 0, 1'b1};
    tbl[1] = '{1'b0, 16'h8003, 8'h00, 48'hA5_02_03_80_00_81, 8'h7E, 1'b0, 5, 1'b0};
    tbl[2] = '{1'b1, 16'h00FF, 8'hAA, 48'hA5_05_FF_00_AA_50, 8'h00, 1'b1, 0, 1'b0};
    tbl[3] = '{1'b0, 16'h1234, 8'h77, 48'hA5_06_34_12_00_20, 8'h99, 1'b0, 0, 1'b1};

    repeat (3) @(negedge clk);
    chk("rst_req_ready", req_ready0, 0);
    chk("rst_resp_valid", resp_valid0, 0);
    chk("rst_resp_rdata", resp_rdata0, 0);
    chk("rst_resp_is_write", resp_is_write0, 0);
    chk("rst_resp_err", resp_err0, 0);
    chk("rst_tx_wr_en", tx_wr_en0, 0);
    chk("rst_tx_data", tx_data0, 0);
    chk("rst_rx_ready_clr", clr0, 0);
    rst = 0;
    @(negedge clk);
    chk("req_ready_first_edge", req_ready0, 1);

    foreach (tbl[i]) begin
      lit2q(tbl[i].f, q);
      txn0(tbl[i].w, tbl[i].a, tbl[i].d, q, tbl[i].rd, tbl[i].e, tbl[i].hold, tbl[i].garb);
    end

    // corrupted reply is ignored and the identical frame is resent after the timeout
    build_req(0, mseq, 64'h8003, 0, 2, 1, q);
    req0(0, 16'h8003, 8'h00);
    wait_tx0(6);
    cmp_tx0("bad_first_frame", q, 0);
    build_rsp(q[1], 64'h7E, 1, r);
    r[3] = r[3] ^ 8'h7E;
    send_q(r);
    seen = 0;
    k = 0;
    while (txq0.size() < 12 && k < 3000) begin @(negedge clk); seen |= resp_valid0; k++; end
    chk("bad_csum_no_resp", seen, 0);
    chk("resend_count", txq0.size(), 12);
    cmp_tx0("resend_frame", q, 6);
    gap = txt0.size() > 6 ? txt0[6] - txt0[5] : 0;
    chk("resend_gap_ok", gap >= TO && gap <= TO + 30, 1);
    build_rsp(q[1], 64'h7E, 1, r);
    send_q(r);
    wait_resp0(100);
    chk("resend_rdata", resp_rdata0, 8'h7E);
    chk("resend_err", resp_err0, 0);
    ack0();

    // silent remote: one attempt plus two retries, then a local error response
    build_req(1, mseq, 64'h0BAD, 64'h3C, 2, 1, q);
    req0(1, 16'h0BAD, 8'h3C);
    wait_tx0(18);
    cmp_tx0("retry1_frame", q, 6);
    cmp_tx0("retry2_frame", q, 12);
    wait_resp0(200);
    chk("giveup_err", resp_err0, 1);
    chk("giveup_rdata", resp_rdata0, 0);
    ack0();
    repeat (3 * TO) @(negedge clk);
    chk("giveup_no_more_frames", txq0.size(), 18);

    // reset in the middle of a frame stops transmission at once
    req0(0, 16'h5555, 8'h00);
    wait_tx0(2);
    rst = 1;
    #1;
    chk("midrst_wr_en", tx_wr_en0, 0);
    chk("midrst_req_ready", req_ready0, 0);
    n = txq0.size();
    repeat (5) @(negedge clk);
    chk("midrst_hold_req_ready", req_ready0, 0);
    chk("midrst_hold_resp_valid", resp_valid0, 0);
    rst = 0;
    mseq = 0;
    @(negedge clk);
    chk("midrst_req_ready_release", req_ready0, 1);
    repeat (30) @(negedge clk);
    chk("midrst_no_more_bytes", txq0.size(), n);

    for (int t = 0; t < 10; t++) begin
      w = 1'($urandom_range(0, 1));
      e = 1'($urandom_range(0, 1));
      garb = 1'($urandom_range(0, 1));
      a = 16'($urandom);
      d = 8'($urandom);
      rd = 8'($urandom);
      build_req(w, mseq, 64'(a), 64'(d), 2, 1, q);
      txn0(w, a, d, q, rd, e, t % 3, garb);
    end

    // wide configuration: 24-bit address, 32-bit data
    rst = 1;
    repeat (2) @(negedge clk);
    rst = 0;
    @(negedge clk);
    txq1.delete();
    req_addr1 = 24'h123456; req_wdata1 = 32'hCAFEF00D; req_is_write1 = 0; req_valid1 = 1;
    k = 0;
    while (!req_ready1 && k < 50) begin @(negedge clk); k++; end
    @(negedge clk);
    req_valid1 = 0;
    k = 0;
    while (txq1.size() < 10 && k < 3000) begin @(negedge clk); k++; end
    repeat (10) @(negedge clk);
    chk("wide_frame_len", txq1.size(), 10);
    build_req(0, 2'd0, 64'h123456, 64'hCAFEF00D, 3, 4, q);
    foreach (q[i]) chk("wide_frame_byte", i < txq1.size() ? txq1[i] : 8'hxx, q[i]);
    build_rsp(8'h00, 64'hDEADBEEF, 4, r);
    send_q(r);
    k = 0;
    while (!resp_valid1 && k < 100) begin @(negedge clk); k++; end
    chk("wide_resp_valid", resp_valid1, 1);
    chk("wide_resp_rdata", resp_rdata1, 32'hDEADBEEF);
    chk("wide_resp_is_write", resp_is_write1, 0);
    chk("wide_resp_err", resp_err1, 0);
    resp_ready1 = 1;
    @(negedge clk);
    resp_ready1 = 0;
    chk("wide_resp_drop", resp_valid1, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/bus_bridge_uart_framer.md
BUS_BRIDGE_UART_FRAMER -- requirements
Module: bus_bridge_uart_framer

Interface
REQ-001 Parameter ADDR_W, default 16: request address width in bits; multiple of 8.
REQ-002 Parameter DATA_W, default 8: read/write data width in bits; multiple of 8.
REQ-003 Parameter TIMEOUT_CYCLES, default 100000: response wait limit in clk cycles.
REQ-004 Parameter MAX_RETRY, default 2: number of re-sends after the first attempt.
REQ-005 Parameter SYNC_BYTE, default 8'hA5: frame start marker.
REQ-006 Port clk, input, 1: the single clock; all logic on its rising edge.
REQ-007 Port rst, input, 1: asynchronous, active-high reset.
REQ-008 Request inputs: req_valid (1), req_addr (ADDR_W), req_wdata (DATA_W), req_is_write (1); output req_ready (1).
REQ-009 Response outputs: resp_valid (1), resp_rdata (DATA_W), resp_is_write (1), resp_err (1); input resp_ready (1).
REQ-010 UART TX side: tx_data (8) and tx_wr_en (1) outputs; tx_busy (1) input.
REQ-011 UART RX side: rx_data (8) and rx_ready (1, level) inputs; rx_ready_clr (1) output.

Function
REQ-012 The block SHALL accept one request at a time; req_ready = 1 only in TX state IDLE, and a transfer occurs on req_valid && req_ready.
REQ-013 The request frame SHALL be: SYNC_BYTE, flags, address bytes LSB first (ADDR_W/8), data bytes LSB first (DATA_W/8), checksum.
REQ-014 Flags SHALL be: bit0 is_write, bits2:1 seq, bit3 err (responses only), bits7:4 zero.
REQ-015 The checksum SHALL be the XOR of all frame bytes after SYNC_BYTE, excluding the checksum byte itself.
REQ-016 Write data bytes SHALL be sent for reads as well, carrying 0.
REQ-017 seq SHALL be a 2-bit counter; it increments on each accepted request, and a retry reuses the same value.
REQ-018 TX FSM states: IDLE -> SEND -> WAIT -> (SEND for the next byte | AWAIT_RESP after the last byte) -> IDLE.
REQ-019 SEND: when tx_busy = 0, drive tx_data and pulse tx_wr_en high for exactly one cycle, then go to WAIT.
REQ-020 WAIT: leave on a tx_busy falling edge (registered tx_busy = 1 and current tx_busy = 0).
REQ-021 AWAIT_RESP: a counter runs from 0; on reaching TIMEOUT_CYCLES-1 with no valid response, the block SHALL resend the whole frame if retries used < MAX_RETRY.
REQ-022 Otherwise on timeout, the block SHALL issue a local response: resp_err = 1, resp_rdata = 0.
REQ-023 The response frame SHALL be: SYNC_BYTE, flags, read data bytes LSB first (DATA_W/8), checksum.
REQ-024 RX FSM states: HUNT -> FLAGS -> DATA (byte counter) -> CHECK -> HOLD -> HUNT.
REQ-025 RX bytes SHALL be taken on an rx_ready rising edge, with rx_ready_clr pulsed for one cycle per byte.
REQ-026 In HUNT, non-SYNC bytes SHALL be discarded.
REQ-027 CHECK SHALL drop the frame silently (back to HUNT, no resp_valid) on checksum mismatch, seq mismatch, is_write mismatch, or when TX is not in AWAIT_RESP.
REQ-028 A good frame SHALL assert resp_valid, with resp_rdata, resp_is_write and resp_err from the frame; the TX FSM then returns to IDLE.
REQ-029 resp_valid and the resp_* outputs SHALL be held stable until resp_valid && resp_ready, then deassert the next cycle.
REQ-030 If a good frame and a timeout occur in the same cycle, the good frame SHALL win and no retry is sent.
REQ-031 Request-to-request latency: no new request is accepted while resp_valid is pending.
REQ-032 The RX FSM SHALL restart HUNT whenever a retry begins, discarding any partial frame.

Reset
REQ-033 While rst = 1, the block SHALL hold: req_ready = 0, resp_valid = 0, resp_rdata = 0, resp_is_write = 0, resp_err = 0, tx_wr_en = 0, tx_data = 0, rx_ready_clr = 0.
REQ-034 While rst = 1, internal state SHALL be: seq = 0, retry count = 0, timeout counter = 0, both FSMs in IDLE/HUNT.
REQ-035 Reset mid-frame SHALL abandon the frame with no further tx_wr_en; after release, req_ready = 1 on the first clock edge.

Verification
REQ-036 Write: addr 16'h4012, wdata 8'h5C -> TX bytes A5,01,12,40,5C,0F; remote replies A5,01,00,01 -> resp_valid, resp_err = 0.
REQ-037 Read: addr 16'h8003 -> TX A5,02,03,80,00,81; reply A5,02,7E,7C -> resp_rdata = 8'h7E, resp_is_write = 0.
REQ-038 Bad checksum reply A5,02,7E,00 -> no resp_valid; after TIMEOUT_CYCLES the identical frame is resent.
REQ-039 No reply with MAX_RETRY = 2 -> exactly 3 frames sent, then resp_err = 1, resp_rdata = 0.
REQ-040 DATA_W = 32, ADDR_W = 24 -> frame length 10 bytes; a 4-byte read reply 32'hDEADBEEF is reassembled LSB first.
REQ-041 Checks: garbage bytes 11,22 before SYNC are ignored; resp_ready held low 5 cycles keeps outputs stable; rst asserted mid-frame stops TX immediately.
